// File: rtl/rv32_alu_seq_if.sv
// Request/result handshake and 16-bit adder-slice bus between the core, the ALU sequencer and the adder unit.
// slave = sequencer side, master = core / adder-unit side.
interface rv32_alu_seq_if #(
    parameter int SLICE_W = 16
);
    logic                   i_valid;
    logic                   o_ready;
    logic [2:0]             i_op;
    logic [2*SLICE_W-1:0]   i_rs1;
    logic [2*SLICE_W-1:0]   i_rs2;
    logic                   o_valid;
    logic                   i_ready;
    logic [2*SLICE_W-1:0]   o_result;
    logic                   o_carry;
    logic [SLICE_W-1:0]     o_add_op_one;
    logic [SLICE_W-1:0]     o_add_op_two;
    logic                   o_add_c_in;
    logic [1:0]             o_add_sel;
    logic [SLICE_W-1:0]     i_add_result;
    logic                   i_add_carry_out;

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_ready, i_add_result, i_add_carry_out,
        output o_ready, o_valid, o_result, o_carry,
               o_add_op_one, o_add_op_two, o_add_c_in, o_add_sel
    );

    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_ready, i_add_result, i_add_carry_out,
        input  o_ready, o_valid, o_result, o_carry,
               o_add_op_one, o_add_op_two, o_add_c_in, o_add_sel
    );
endinterface

// File: rtl/rv32_alu_seq.sv
// 32-bit RV32 ALU op built from two passes through a 16-bit adder slice; result valid 3 cycles after accept.
// One op in flight: o_ready is low from accept until the result is taken; result held while i_ready is low.
module rv32_alu_seq #(
    parameter int SLICE_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rv32_alu_seq_if.slave bus
);
    localparam int W = 2 * SLICE_W;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t               state_q;
    logic [2:0]           op_q;
    logic [W-1:0]         rs1_q;
    logic [W-1:0]         rs2_q;
    logic [SLICE_W-1:0]   res_lo_q;
    logic                 carry_lo_q;
    logic [W-1:0]         result_q;
    logic                 carry_q;
    logic                 ready_q;
    logic                 valid_q;

    logic                 is_sub;
    logic                 is_logic;
    logic [1:0]           sel;
    logic [W-1:0]         rs2_prep;
    logic                 carry_d;
    logic                 slt_bit;
    logic [W-1:0]         sum_full;
    logic [W-1:0]         result_d;

    always_comb begin
        is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
        is_logic = (op_q == OP_OR) || (op_q == OP_AND) || (op_q == OP_XOR);
        case (op_q)
            OP_OR:   sel = 2'b01;
            OP_AND:  sel = 2'b10;
            OP_XOR:  sel = 2'b11;
            default: sel = 2'b00;
        endcase
        rs2_prep = is_sub ? ~rs2_q : rs2_q;
    end

    // Slice drive is decoded from the state register so the adder sees a clean value each phase.
    always_comb begin
        bus.o_add_op_one = '0;
        bus.o_add_op_two = '0;
        bus.o_add_c_in   = 1'b0;
        bus.o_add_sel    = 2'b00;
        case (state_q)
            LO: begin
                bus.o_add_op_one = rs1_q[SLICE_W-1:0];
                bus.o_add_op_two = rs2_prep[SLICE_W-1:0];
                bus.o_add_c_in   = is_sub;
                bus.o_add_sel    = sel;
            end
            HI: begin
                bus.o_add_op_one = rs1_q[W-1:SLICE_W];
                bus.o_add_op_two = rs2_prep[W-1:SLICE_W];
                bus.o_add_c_in   = ~is_logic & carry_lo_q;
                bus.o_add_sel    = sel;
            end
            default: ;
        endcase
    end

    // Comparisons need the final carry of rs1 + ~rs2 + 1, so they resolve at the end of HI.
    always_comb begin
        carry_d  = ~is_logic & bus.i_add_carry_out;
        sum_full = {bus.i_add_result, res_lo_q};
        slt_bit  = (rs1_q[W-1] ^ rs2_q[W-1]) ? rs1_q[W-1] : ~carry_d;
        case (op_q)
            OP_SLT:  result_d = {{(W-1){1'b0}}, slt_bit};
            OP_SLTU: result_d = {{(W-1){1'b0}}, ~carry_d};
            default: result_d = sum_full;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            res_lo_q   <= '0;
            carry_lo_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        op_q    <= bus.i_op;
                        rs1_q   <= bus.i_rs1;
                        rs2_q   <= bus.i_rs2;
                        ready_q <= 1'b0;
                        state_q <= LO;
                    end
                end
                LO: begin
                    res_lo_q   <= bus.i_add_result;
                    carry_lo_q <= carry_d;
                    state_q    <= HI;
                end
                HI: begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_carry  = carry_q;
endmodule

// File: tb/tb_rv32_alu_seq.sv
// Bench for rv32_alu_seq: behavioural 16-bit adder slice plus a result scoreboard per scenario.
module tb_rv32_alu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_alu_seq_if bus ();

    rv32_alu_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q [$];

    // Adder slice; logic ops deliberately raise carry-out so the sequencer must ignore it.
    logic [15:0] add_res;
    logic        add_co;
    always_comb begin
        add_res = '0;
        add_co  = 1'b0;
        case (bus.o_add_sel)
            2'b00: {add_co, add_res} = {1'b0, bus.o_add_op_one} + {1'b0, bus.o_add_op_two}
                                       + {16'b0, bus.o_add_c_in};
            2'b01: begin add_res = bus.o_add_op_one | bus.o_add_op_two; add_co = 1'b1; end
            2'b10: begin add_res = bus.o_add_op_one & bus.o_add_op_two; add_co = 1'b1; end
            default: begin add_res = bus.o_add_op_one ^ bus.o_add_op_two; add_co = 1'b1; end
        endcase
    end
    assign bus.i_add_result    = add_res;
    assign bus.i_add_carry_out = add_co;

    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        case (op)
            3'b001: t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'b010: t = {1'b0, a | b};
            3'b011: t = {1'b0, a & b};
            3'b100: t = {1'b0, a ^ b};
            3'b101: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                t = {t[32], 31'b0, ($signed(a) < $signed(b))};
            end
            3'b110: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                t = {t[32], 31'b0, (a < b)};
            end
            default: t = {1'b0, a} + {1'b0, b};
        endcase
        return t;
    endfunction

    // Called at a falling edge; presents the request for one cycle and returns in LO.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp);
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        bus.i_valid = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!bus.o_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_op = 3'b000; bus.i_rs1 = 32'd1; bus.i_rs2 = 32'd1; bus.i_valid = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs got ready=%b valid=%b want ready=1 valid=0", bus.o_ready, bus.o_valid);
        end
        total++;
        if (bus.o_result !== 32'h0 || bus.o_carry !== 1'b0) begin
            bad++; $display("FAIL reset_result got %h/%b want 0/0", bus.o_result, bus.o_carry);
        end
        total++;
        if ({bus.o_add_op_one, bus.o_add_op_two, bus.o_add_c_in, bus.o_add_sel} !== 35'h0) begin
            bad++; $display("FAIL reset_adder_drive got %h %h %b %b want all 0",
                            bus.o_add_op_one, bus.o_add_op_two, bus.o_add_c_in, bus.o_add_sel);
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
                bad++; $display("FAIL reset_no_accept cyc%0d got valid=%b ready=%b want 0/1", k, bus.o_valid, bus.o_ready);
            end
        end
    endtask

    task automatic test_add;
        logic [31:0] a_t [3] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] b_t [3] = '{32'h00000001, 32'h00000001, 32'h0000FFFF};
        logic [32:0] e_t [3] = '{{1'b0, 32'h00010000}, {1'b1, 32'h00000000}, {1'b0, 32'h12355677}};
        logic [32:0] exp;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue(3'b000, a_t[i], b_t[i], e_t[i]);
            wait_valid(1, cyc);
            exp = exp_q.pop_front();
            total++;
            if (cyc !== 3) begin bad++; $display("FAIL add_latency[%0d] got=%0d want=3", i, cyc); end
            total++;
            if ({bus.o_carry, bus.o_result} !== exp) begin
                bad++; $display("FAIL add[%0d] got c=%b r=%h want c=%b r=%h", i, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub_cmp;
        logic [2:0]  o_t [5] = '{3'b001, 3'b001, 3'b101, 3'b110, 3'b101};
        logic [31:0] a_t [5] = '{32'd5, 32'd7, 32'h80000000, 32'h80000000, 32'd5};
        logic [31:0] b_t [5] = '{32'd7, 32'd5, 32'h00000001, 32'h00000001, 32'd5};
        logic [32:0] e_t [5] = '{{1'b0, 32'hFFFFFFFE}, {1'b1, 32'h00000002}, {1'b1, 32'h00000001},
                                 {1'b1, 32'h00000000}, {1'b1, 32'h00000000}};
        logic [32:0] exp;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            issue(o_t[i], a_t[i], b_t[i], e_t[i]);
            total++;
            if (bus.o_add_c_in !== 1'b1 || bus.o_add_sel !== 2'b00) begin
                bad++; $display("FAIL subcmp_lo_cin[%0d] got cin=%b sel=%b want 1/00", i, bus.o_add_c_in, bus.o_add_sel);
            end
            wait_valid(1, cyc);
            exp = exp_q.pop_front();
            total++;
            if ({bus.o_carry, bus.o_result} !== exp) begin
                bad++; $display("FAIL subcmp[%0d] got c=%b r=%h want c=%b r=%h", i, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_logic;
        logic [2:0]  o_t [3] = '{3'b011, 3'b010, 3'b100};
        logic [1:0]  s_t [3] = '{2'b10, 2'b01, 2'b11};
        logic [32:0] e_t [3] = '{{1'b0, 32'h00F01200}, {1'b0, 32'hFFF0FF34}, {1'b0, 32'hFF00ED34}};
        logic [32:0] exp;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue(o_t[i], 32'hF0F01234, 32'h0FF0FF00, e_t[i]);
            total++;
            if (bus.o_add_sel !== s_t[i] || bus.o_add_c_in !== 1'b0) begin
                bad++; $display("FAIL logic_lo_sel[%0d] got sel=%b cin=%b want %b/0", i, bus.o_add_sel, bus.o_add_c_in, s_t[i]);
            end
            @(negedge clk);
            total++;
            if (bus.o_add_sel !== s_t[i] || bus.o_add_c_in !== 1'b0 || bus.o_add_op_one !== 16'hF0F0) begin
                bad++; $display("FAIL logic_hi_sel[%0d] got sel=%b cin=%b op1=%h want %b/0/f0f0",
                                i, bus.o_add_sel, bus.o_add_c_in, bus.o_add_op_one, s_t[i]);
            end
            wait_valid(2, cyc);
            exp = exp_q.pop_front();
            total++;
            if ({bus.o_carry, bus.o_result} !== exp) begin
                bad++; $display("FAIL logic[%0d] got c=%b r=%h want c=%b r=%h", i, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reserved;
        logic [32:0] exp;
        int cyc;
        issue(3'b111, 32'hFFFFFFFF, 32'h00000002, {1'b1, 32'h00000001});
        wait_valid(1, cyc);
        exp = exp_q.pop_front();
        total++;
        if ({bus.o_carry, bus.o_result} !== exp) begin
            bad++; $display("FAIL reserved_op got c=%b r=%h want c=%b r=%h", bus.o_carry, bus.o_result, exp[32], exp[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [32:0] exp;
        int cyc;
        bus.i_ready = 1'b0;
        issue(3'b000, 32'h7FFFFFFF, 32'h00000001, {1'b0, 32'h80000000});
        wait_valid(1, cyc);
        exp = exp_q.pop_front();
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                bus.i_op = 3'b001; bus.i_rs1 = 32'h55; bus.i_rs2 = 32'h22; bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || {bus.o_carry, bus.o_result} !== exp) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b c=%b r=%h want v=1 rdy=0 c=%b r=%h",
                                k, bus.o_valid, bus.o_ready, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
            end
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", bus.o_valid, bus.o_ready);
        end
        issue(3'b001, 32'h00000010, 32'h00000003, {1'b1, 32'h0000000D});
        wait_valid(1, cyc);
        exp = exp_q.pop_front();
        total++;
        if (cyc !== 3 || {bus.o_carry, bus.o_result} !== exp) begin
            bad++; $display("FAIL bp_next got cyc=%0d c=%b r=%h want cyc=3 c=%b r=%h",
                            cyc, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        logic [32:0] exp;
        int cyc;
        int seen;
        issue(3'b000, 32'h11111111, 32'h22222222, {1'b0, 32'h33333333});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_result !== 32'h0 || bus.o_carry !== 1'b0) begin
            bad++; $display("FAIL midreset_state got v=%b rdy=%b r=%h c=%b want 0/1/0/0",
                            bus.o_valid, bus.o_ready, bus.o_result, bus.o_carry);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.o_valid === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midreset_no_emit got valid_cycles=%0d want 0", seen); end
        issue(3'b000, 32'd1, 32'd2, {1'b0, 32'h00000003});
        wait_valid(1, cyc);
        exp = exp_q.pop_front();
        total++;
        if ({bus.o_carry, bus.o_result} !== exp) begin
            bad++; $display("FAIL midreset_next got c=%b r=%h want c=%b r=%h", bus.o_carry, bus.o_result, exp[32], exp[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;
        int cyc;
        int start_t;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = (i % 4 == 0) ? 32'h80000000 : $urandom;
            b  = (i % 6 == 1) ? a : ((i % 5 == 2) ? 32'hFFFFFFFF : $urandom);
            start_t = cyc;
            issue(op, a, b, model(op, a, b));
            wait_valid(1, cyc);
            exp = exp_q.pop_front();
            total++;
            if (cyc !== 3 || {bus.o_carry, bus.o_result} !== exp) begin
                bad++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h got cyc=%0d c=%b r=%h want cyc=3 c=%b r=%h",
                                i, op, a, b, cyc, bus.o_carry, bus.o_result, exp[32], exp[31:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_op    = 3'b000;
        bus.i_rs1   = '0;
        bus.i_rs2   = '0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic();
        test_reserved();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
